// File: rtl/l2_mem_arbiter_if.sv
// l2_mem_arbiter_if: I-side, D-side and memory-side signals of the L2 line-memory arbiter.
//   slave  : arbiter view (requests and memory responses in; strobes, data and ready pulses out)
//   master : environment view (requesters plus memory)
interface l2_mem_arbiter_if;
    logic         I_read;
    logic [27:0]  I_addr;
    logic [127:0] I_rdata;
    logic         I_ready;
    logic         D_read;
    logic         D_write;
    logic [27:0]  D_addr;
    logic [127:0] D_wdata;
    logic [127:0] D_rdata;
    logic         D_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         grant_I;
    logic         grant_D;

    modport slave (
        input  I_read, I_addr, D_read, D_write, D_addr, D_wdata, mem_rdata, mem_ready,
        output I_rdata, I_ready, D_rdata, D_ready, mem_read, mem_write, mem_addr, mem_wdata,
               grant_I, grant_D
    );

    modport master (
        output I_read, I_addr, D_read, D_write, D_addr, D_wdata, mem_rdata, mem_ready,
        input  I_rdata, I_ready, D_rdata, D_ready, mem_read, mem_write, mem_addr, mem_wdata,
               grant_I, grant_D
    );
endinterface

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares one 128-bit line memory port between the I-side and D-side miss paths.
//   clk, proc_reset : clock and synchronous active-high reset
//   bus (slave)     : I/D level requests with one-cycle ready pulses, registered memory strobes,
//                     address and write line, memory ready/read line, grant status
// D-side has priority; after STARVE_LIMIT consecutive D grants with I waiting, I is forced in.
module l2_mem_arbiter #(
    parameter int STARVE_LIMIT = 2,
    parameter int CNT_W        = 4
) (
    input logic              clk,
    input logic              proc_reset,
    l2_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] starve_cnt;
    logic             d_req, pick_i;

    always_comb begin
        d_req   = bus.D_read | bus.D_write;
        pick_i  = bus.I_read & (~d_req | (starve_cnt >= CNT_W'(STARVE_LIMIT)));
        state_n = (state == IDLE) ? (pick_i ? GNT_I : (d_req ? GNT_D : IDLE))
                                  : (bus.mem_ready ? IDLE : state);
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n == GNT_I) begin
                bus.mem_read  <= 1'b1;
                bus.mem_write <= 1'b0;
                bus.mem_addr  <= bus.I_addr;
                bus.mem_wdata <= '0;
                starve_cnt    <= '0;
            end else if (state == IDLE && state_n == GNT_D) begin
                // D_read together with D_write is treated as a write-back
                bus.mem_read  <= ~bus.D_write;
                bus.mem_write <= bus.D_write;
                bus.mem_addr  <= bus.D_addr;
                bus.mem_wdata <= bus.D_wdata;
                starve_cnt    <= bus.I_read ? ((starve_cnt == '1) ? starve_cnt : starve_cnt + 1'b1) : '0;
            end else if (state != IDLE && state_n == IDLE) begin
                // clearing here gives memory one dead cycle with strobes low
                bus.mem_read  <= 1'b0;
                bus.mem_write <= 1'b0;
                bus.mem_addr  <= '0;
                bus.mem_wdata <= '0;
            end
        end
    end

    assign bus.grant_I = (state == GNT_I);
    assign bus.grant_D = (state == GNT_D);
    assign bus.I_ready = bus.mem_ready & (state == GNT_I);
    assign bus.D_ready = bus.mem_ready & (state == GNT_D);
    assign bus.I_rdata = bus.mem_rdata;
    assign bus.D_rdata = bus.mem_rdata;
endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: randomized requesters and memory checked against a port-ownership reference model.
module tb_l2_mem_arbiter;
    logic clk = 1'b0;
    logic proc_reset;
    always #5 clk = ~clk;

    l2_mem_arbiter_if bus();

    l2_mem_arbiter #(.STARVE_LIMIT(2), .CNT_W(4)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus)
    );

    localparam int LIMIT = 2;
    localparam int CNT_MAX = 15;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: who owns the memory port (0 none, 1 I, 2 D), the fairness count,
    // and what the memory port should currently present.
    int           own, cnt, k;
    logic [27:0]  ea;
    logic [127:0] ewd;
    logic         erd, ewr, i_done, d_done, was_rst, dreq;

    initial begin
        proc_reset    = 1'b1;
        bus.I_read    = 1'b0;
        bus.I_addr    = '0;
        bus.D_read    = 1'b0;
        bus.D_write   = 1'b0;
        bus.D_addr    = '0;
        bus.D_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        own = 0; cnt = 0; ea = '0; ewd = '0; erd = 1'b0; ewr = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            chk("grant_I",   bus.grant_I,   own == 1);
            chk("grant_D",   bus.grant_D,   own == 2);
            chk("mem_read",  bus.mem_read,  erd);
            chk("mem_write", bus.mem_write, ewr);
            chk("mem_addr",  bus.mem_addr,  ea);
            chk("mem_wdata", bus.mem_wdata, ewd);
            chk("I_ready",   bus.I_ready,   own == 1 && bus.mem_ready);
            chk("D_ready",   bus.D_ready,   own == 2 && bus.mem_ready);
            chk("I_rdata",   bus.I_rdata,   bus.mem_rdata);
            chk("D_rdata",   bus.D_rdata,   bus.mem_rdata);
            i_done  = (own == 1) && bus.mem_ready;
            d_done  = (own == 2) && bus.mem_ready;
            was_rst = proc_reset;
            dreq    = bus.D_read | bus.D_write;
            if (proc_reset) begin
                own = 0; cnt = 0; ea = '0; ewd = '0; erd = 1'b0; ewr = 1'b0;
            end else if (own == 0) begin
                if (bus.I_read && (!dreq || cnt >= LIMIT)) begin
                    own = 1; cnt = 0; ea = bus.I_addr; ewd = '0; erd = 1'b1; ewr = 1'b0;
                end else if (dreq) begin
                    own = 2;
                    cnt = bus.I_read ? ((cnt + 1 > CNT_MAX) ? CNT_MAX : cnt + 1) : 0;
                    ea = bus.D_addr; ewd = bus.D_wdata; ewr = bus.D_write; erd = !bus.D_write;
                end
            end else if (bus.mem_ready) begin
                own = 0; ea = '0; ewd = '0; erd = 1'b0; ewr = 1'b0;
            end
            @(posedge clk); #1;
            proc_reset = ($urandom % 150 == 0);
            if (was_rst || i_done) bus.I_read = 1'b0;
            if (was_rst || d_done) begin
                bus.D_read  = 1'b0;
                bus.D_write = 1'b0;
            end
            if (!bus.I_read && $urandom % 3 == 0) begin
                bus.I_read = 1'b1;
                bus.I_addr = 28'($urandom);
            end
            if (!bus.D_read && !bus.D_write && $urandom % 4 != 0) begin
                k = int'($urandom % 16);
                bus.D_write = (k < 7) || (k == 15);
                bus.D_read  = (k >= 7);
                bus.D_addr  = 28'($urandom);
                bus.D_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            bus.mem_ready = (erd | ewr) ? ($urandom % 3 == 0) : ($urandom % 6 == 0);
            bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
- Shares one 128-bit line memory port between the I-side miss path (read only) and the D-side miss path (read and write-back) of the L2 cache.
- Each requester holds a level request until it receives a one-cycle ready pulse.
- The arbiter grants one requester at a time and drives registered memory controls, then routes the memory ready and read data back to the granted side.
- Policy is D-priority, with a starvation limit that forces an I grant.

Parameters:
- STARVE_LIMIT, 2: number of consecutive D grants allowed while I is waiting before I must be granted. Legal range 1..15.
- CNT_W, 4: width of the starvation counter.

Ports:
- clk  in  1  clock
- proc_reset  in  1  synchronous active-high reset
- I_read  in  1  I-side line read request (level, held until I_ready)
- I_addr  in  28  I-side line address
- I_rdata  out  128  read line to I side
- I_ready  out  1  one-cycle completion pulse to I side
- D_read  in  1  D-side line read request (level)
- D_write  in  1  D-side line write-back request (level)
- D_addr  in  28  D-side line address
- D_wdata  in  128  D-side write-back line
- D_rdata  out  128  read line to D side
- D_ready  out  1  one-cycle completion pulse to D side
- mem_read  out  1  memory read strobe (registered)
- mem_write  out  1  memory write strobe (registered)
- mem_addr  out  28  memory line address (registered)
- mem_wdata  out  128  memory write line (registered)
- mem_rdata  in  128  memory read line
- mem_ready  in  1  memory completion pulse
- grant_I  out  1  status: state is GNT_I
- grant_D  out  1  status: state is GNT_D

Behaviour:

Reset (proc_reset high at a clk edge):
- state goes to IDLE and starve_cnt to 0.
- mem_read, mem_write, mem_addr and mem_wdata go to 0.
- grant_I, grant_D, I_ready and D_ready read 0.
- A transaction in flight is abandoned. The requester must re-request after reset.

States: IDLE, GNT_I, GNT_D.

In IDLE, evaluated every cycle:
- No request: stay in IDLE. Memory outputs hold 0.
- Only I_read: go to GNT_I.
- Only D_read or D_write: go to GNT_D.
- Both sides requesting: GNT_I if starve_cnt >= STARVE_LIMIT, otherwise GNT_D.

On the IDLE-to-grant edge:
- mem_addr and mem_wdata load from the granted side.
- For GNT_I: mem_read=1, mem_write=0.
- For GNT_D: mem_write=D_write and mem_read=~D_write.
- Latency: a request first seen at cycle t gives a memory strobe visible at t+1.

In GNT_x while mem_ready=0:
- Stay in GNT_x.
- Memory outputs hold.
- Requester inputs are ignored (already latched).

In GNT_x while mem_ready=1:
- x_ready is asserted in the same cycle (combinational).
- Next state is IDLE. At that edge mem_read, mem_write, mem_addr and mem_wdata clear to 0.
- The next grant's strobe appears no earlier than 2 cycles after the mem_ready cycle. There is one dead IDLE cycle so memory sees its strobe drop.

Read data path:
- I_rdata = mem_rdata and D_rdata = mem_rdata, unconditionally.
- Data is valid only in the x_ready cycle.

Ready gating:
- I_ready = mem_ready & (state==GNT_I).
- D_ready = mem_ready & (state==GNT_D).
- mem_ready in IDLE is ignored: no ready pulse and no state change.

Starvation counter:
- It changes only on the IDLE-to-grant edge.
- D granted while I_read=1: increment, saturating at 2^CNT_W-1.
- I granted: clear to 0.
- D granted while I_read=0: clear to 0.

D_read and D_write both high is illegal. The arbiter treats it as a write-back (mem_write=1, mem_read=0).

mem_read and mem_write are never both 1.

Test Plan:
1. I_read=1, I_addr=28'h0000123 alone at cycle 0 -> mem_read=1 and mem_addr=28'h0000123 at cycle 1. Memory returns mem_ready with mem_rdata=128'hA5..A5 at cycle 4 -> I_ready=1 with I_rdata=128'hA5..A5 at cycle 4. mem_read=0 at cycle 5.
2. D_write=1, D_addr=28'h00000FF, D_wdata=128'h1 -> mem_write=1, mem_read=0, mem_wdata=128'h1 one cycle later. D_ready pulses on mem_ready. I_ready stays 0 throughout.
3. I_read and D_read rise in the same cycle with starve_cnt=0 -> D served first. I is granted on the first IDLE cycle after D completes, with no strobe in the dead cycle. starve_cnt is 1, then 0.
4. STARVE_LIMIT=2, D re-requests immediately after every completion, I_read held high -> grant order D, D, I. starve_cnt goes 1, 2, 0.
5. mem_ready pulsed while in IDLE with no requests -> I_ready=0, D_ready=0, state stays IDLE.
6. proc_reset asserted while in GNT_D with mem_write=1 -> the next cycle shows mem_write=0, mem_addr=0, grant_D=0, starve_cnt=0. After reset deasserts with I_read held, GNT_I is entered one cycle later.
